// File: rtl/bp_wupdate_if.sv
// Bus bundle for the weight-update engine: control handshake plus the
// delta, input and weight memory ports.
interface bp_wupdate_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_D = 9,
    parameter int ADDR_X = 9,
    parameter int ADDR_W = 12
);
    logic              i_start;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_D-1:0] o_rd_addr_d;
    logic [WIDTH-1:0]  i_dgate;
    logic [ADDR_X-1:0] o_rd_addr_x;
    logic [WIDTH-1:0]  i_x;
    logic [ADDR_W-1:0] o_rd_addr_w;
    logic [WIDTH-1:0]  i_w;
    logic              o_wr_w;
    logic [ADDR_W-1:0] o_wr_addr_w;
    logic [WIDTH-1:0]  o_wr_data_w;
    logic [WIDTH-1:0]  o_dw;

    modport slave (
        input  i_start, i_dgate, i_x, i_w,
        output o_busy, o_done, o_rd_addr_d, o_rd_addr_x, o_rd_addr_w,
               o_wr_w, o_wr_addr_w, o_wr_data_w, o_dw
    );

    modport master (
        output i_start, i_dgate, i_x, i_w,
        input  o_busy, o_done, o_rd_addr_d, o_rd_addr_x, o_rd_addr_w,
               o_wr_w, o_wr_addr_w, o_wr_data_w, o_dw
    );
endinterface

// File: rtl/bp_wupdate.sv
// Weight-gradient accumulation and SGD write-back for one gate matrix:
// dW[j][k] = sum_t dgate[t][j]*x[t][k], w_new = sat(w - LR*dW).
module bp_wupdate #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 24,
    parameter int N_CELL   = 53,
    parameter int N_IN     = 53,
    parameter int TIMESTEP = 7,
    parameter int ADDR_D   = 9,
    parameter int ADDR_X   = 9,
    parameter int ADDR_W   = 12,
    parameter logic [WIDTH-1:0] LR = 32'h00028F5C
) (
    input logic        clk,
    input logic        rst,
    bp_wupdate_if.slave bus
);
    localparam int ACC_W = 2*WIDTH + 4;
    localparam int JW    = $clog2(N_CELL + 1);
    localparam int KW    = $clog2(N_IN + 1);
    localparam int TW    = $clog2(TIMESTEP + 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_CELL - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMESTEP - 1);
    localparam logic signed [WIDTH-1:0] LR_S = LR;

    typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_UPD, S_WR, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [JW-1:0]             j_q, j_d;
    logic [KW-1:0]             k_q, k_d;
    logic [TW-1:0]             t_q, t_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [ADDR_D-1:0]         addr_d_q, addr_d_d;
    logic [ADDR_X-1:0]         addr_x_q, addr_x_d;
    logic [ADDR_W-1:0]         addr_w_q, addr_w_d;
    logic                      wr_q, wr_d;
    logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]          wr_data_q, wr_data_d;
    logic [WIDTH-1:0]          dw_q, dw_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [2*WIDTH-1:0] upd_prod;
    logic signed [ACC_W-1:0]   w_diff;

    // Clamp a wide signed value into a WIDTH-bit signed word.
    function automatic logic [WIDTH-1:0] sat_w(input logic signed [ACC_W-1:0] v);
        if ((&v[ACC_W-1:WIDTH-1]) || !(|v[ACC_W-1:WIDTH-1]))
            return v[WIDTH-1:0];
        else if (v[ACC_W-1])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            j_q       <= '0;
            k_q       <= '0;
            t_q       <= '0;
            acc_q     <= '0;
            addr_d_q  <= '0;
            addr_x_q  <= '0;
            addr_w_q  <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            dw_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            t_q       <= t_d;
            acc_q     <= acc_d;
            addr_d_q  <= addr_d_d;
            addr_x_q  <= addr_x_d;
            addr_w_q  <= addr_w_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            dw_q      <= dw_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, counters, running address offsets and arithmetic.
    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        k_d       = k_q;
        t_d       = t_q;
        acc_d     = acc_q;
        addr_d_d  = addr_d_q;
        addr_x_d  = addr_x_q;
        addr_w_d  = addr_w_q;
        wr_d      = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        dw_d      = dw_q;

        prod     = (2*WIDTH)'($signed(bus.i_dgate)) * (2*WIDTH)'($signed(bus.i_x));
        acc_sum  = acc_q + ACC_W'(prod);
        upd_prod = (2*WIDTH)'($signed(dw_q)) * (2*WIDTH)'(LR_S);
        w_diff   = ACC_W'($signed(bus.i_w)) - (ACC_W'(upd_prod) >>> FRAC);

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    j_d      = '0;
                    k_d      = '0;
                    t_d      = '0;
                    acc_d    = '0;
                    addr_d_d = '0;
                    addr_x_d = '0;
                    addr_w_d = '0;
                    state_d  = S_ACC;
                end
            end
            S_ACC: begin
                // Read data lags the address by one cycle, so the first ACC
                // cycle has nothing to add and DRAIN picks up the last product.
                if (t_q != '0) acc_d = acc_sum;
                if (t_q == T_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    t_d      = t_q + TW'(1);
                    addr_d_d = addr_d_q + ADDR_D'(N_CELL);
                    addr_x_d = addr_x_q + ADDR_X'(N_IN);
                end
            end
            S_DRAIN: begin
                acc_d   = acc_sum;
                dw_d    = sat_w(acc_sum >>> FRAC);
                state_d = S_UPD;
            end
            S_UPD: begin
                wr_d      = 1'b1;
                wr_addr_d = addr_w_q;
                wr_data_d = sat_w(w_diff);
                state_d   = S_WR;
            end
            S_WR: begin
                acc_d = '0;
                t_d   = '0;
                if (j_q == J_LAST && k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        j_d = j_q + JW'(1);
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                    addr_d_d = ADDR_D'(j_d);
                    addr_x_d = ADDR_X'(k_d);
                    addr_w_d = addr_w_q + ADDR_W'(1);
                    state_d  = S_ACC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ACC) || (state_d == S_DRAIN) ||
                 (state_d == S_UPD) || (state_d == S_WR);
        done_d = (state_d == S_DONE);
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_rd_addr_d = addr_d_q;
    assign bus.o_rd_addr_x = addr_x_q;
    assign bus.o_rd_addr_w = addr_w_q;
    assign bus.o_wr_w      = wr_q;
    assign bus.o_wr_addr_w = wr_addr_q;
    assign bus.o_wr_data_w = wr_data_q;
    assign bus.o_dw        = dw_q;
endmodule

// File: tb/tb_bp_wupdate.sv
// Directed bench for bp_wupdate: three small configurations, a write
// scoreboard per instance, and cycle-exact address/latency checks.
module tb_bp_wupdate;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    wr_t qc[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  wcnt_a = 0, wcnt_b = 0, wcnt_c = 0;
    int  dcnt_a = 0, dcnt_b = 0, dcnt_c = 0;

    bp_wupdate_if ifa ();
    bp_wupdate_if ifb ();
    bp_wupdate_if ifc ();

    bp_wupdate #(.N_CELL(1), .N_IN(1), .TIMESTEP(2), .LR(32'h00800000))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    bp_wupdate #(.N_CELL(2), .N_IN(3), .TIMESTEP(2), .LR(32'h00800000))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    bp_wupdate #(.N_CELL(1), .N_IN(1), .TIMESTEP(2), .LR(32'h01000000))
        u_c (.clk(clk), .rst(rst), .bus(ifc));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic, written independently with wide signed math.
    function automatic logic [31:0] sat32(input logic signed [79:0] v);
        if (v > 80'sh7FFFFFFF) return 32'h7FFFFFFF;
        if (v < -80'sh80000000) return 32'h80000000;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_dw(input logic [31:0] d, input logic [31:0] x, input int t);
        logic signed [79:0] dd, xx, acc;
        dd  = $signed(d);
        xx  = $signed(x);
        acc = dd * xx * t;
        return sat32(acc >>> 24);
    endfunction

    function automatic logic [31:0] m_w(input logic [31:0] dw, input logic [31:0] w, input logic [31:0] lr);
        logic signed [79:0] a, b, c;
        a = $signed(dw);
        b = $signed(lr);
        c = $signed(w);
        return sat32(c - ((a * b) >>> 24));
    endfunction

    // Write monitors: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (ifa.o_done) dcnt_a++;
        if (ifa.o_wr_w) begin
            wcnt_a++;
            check("a_wr_pending", 64'(qa.size() > 0), 64'd1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a_wr_addr", 64'(ifa.o_wr_addr_w), 64'(e.a));
                check("a_wr_data", 64'(ifa.o_wr_data_w), 64'(e.d));
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (ifb.o_done) dcnt_b++;
        if (ifb.o_wr_w) begin
            wcnt_b++;
            check("b_wr_pending", 64'(qb.size() > 0), 64'd1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b_wr_addr", 64'(ifb.o_wr_addr_w), 64'(e.a));
                check("b_wr_data", 64'(ifb.o_wr_data_w), 64'(e.d));
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (ifc.o_done) dcnt_c++;
        if (ifc.o_wr_w) begin
            wcnt_c++;
            check("c_wr_pending", 64'(qc.size() > 0), 64'd1);
            if (qc.size() > 0) begin
                e = qc.pop_front();
                check("c_wr_addr", 64'(ifc.o_wr_addr_w), 64'(e.a));
                check("c_wr_data", 64'(ifc.o_wr_data_w), 64'(e.d));
            end
        end
    end

    // Pulse start for one cycle; returns at the first negedge after acceptance.
    task automatic pulse_start(input int w);
        @(negedge clk);
        case (w)
            0: ifa.i_start = 1'b1;
            1: ifb.i_start = 1'b1;
            default: ifc.i_start = 1'b1;
        endcase
        @(negedge clk);
        ifa.i_start = 1'b0;
        ifb.i_start = 1'b0;
        ifc.i_start = 1'b0;
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0: return ifa.o_done;
            1: return ifb.o_done;
            default: return ifc.o_done;
        endcase
    endfunction

    // Count negedges from acceptance until o_done, bounded.
    task automatic wait_done(input int w, output int n);
        n = 1;
        while (!done_of(w) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done_of(w)) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        logic [31:0] d, x, wv, dwx;
        ifa.i_start = 0; ifa.i_dgate = '0; ifa.i_x = '0; ifa.i_w = '0;
        ifb.i_start = 0; ifb.i_dgate = '0; ifb.i_x = '0; ifb.i_w = '0;
        ifc.i_start = 0; ifc.i_dgate = '0; ifc.i_x = '0; ifc.i_w = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy", 64'(ifb.o_busy), 64'd0);
        check("rst_done", 64'(ifb.o_done), 64'd0);
        check("rst_wr", 64'(ifb.o_wr_w), 64'd0);
        check("rst_addr_d", 64'(ifb.o_rd_addr_d), 64'd0);
        check("rst_addr_x", 64'(ifb.o_rd_addr_x), 64'd0);
        check("rst_addr_w", 64'(ifb.o_rd_addr_w), 64'd0);
        check("rst_dw", 64'(ifa.o_dw), 64'd0);
        check("rst_wdata", 64'(ifa.o_wr_data_w), 64'd0);

        // Basic update
        ifa.i_dgate = 32'h01000000; ifa.i_x = 32'h00800000; ifa.i_w = 32'h01000000;
        qa.push_back('{a: 12'd0, d: 32'h00800000});
        pulse_start(0);
        check("a_busy_acc", 64'(ifa.o_busy), 64'd1);
        wait_done(0, n);
        check("a_done_lat", 64'(n), 64'd6);
        check("a_dw", 64'(ifa.o_dw), 64'h01000000);
        check("a_busy_done", 64'(ifa.o_busy), 64'd0);
        @(negedge clk);
        check("a_done_pulse", 64'(ifa.o_done), 64'd0);
        check("a_wcnt", 64'(wcnt_a), 64'd1);

        // Negative truncation toward -inf: -2 LSB of product >>> FRAC = -1
        ifa.i_dgate = 32'hFFFFFFFF; ifa.i_x = 32'h00000001; ifa.i_w = 32'h00000000;
        qa.push_back('{a: 12'd0, d: m_w(32'hFFFFFFFF, 32'h0, 32'h00800000)});
        pulse_start(0);
        wait_done(0, n);
        check("a_neg_dw", 64'(ifa.o_dw), 64'hFFFFFFFF);

        // Address sweep with start pulses during ACC and DONE
        d = 32'h00400000; x = 32'hFFC00000; wv = 32'h00100000;
        ifb.i_dgate = d; ifb.i_x = x; ifb.i_w = wv;
        dwx = m_dw(d, x, 2);
        for (int e = 0; e < 6; e++) qb.push_back('{a: 12'(e), d: m_w(dwx, wv, 32'h00800000)});
        pulse_start(1);
        for (int e = 0; e < 6; e++) begin
            for (int t = 0; t < 2; t++) begin
                check("b_addr_d", 64'(ifb.o_rd_addr_d), 64'(t*2 + e/3));
                check("b_addr_x", 64'(ifb.o_rd_addr_x), 64'(t*3 + e%3));
                check("b_addr_w", 64'(ifb.o_rd_addr_w), 64'(e));
                ifb.i_start = (e == 1 && t == 0);
                @(negedge clk);
                ifb.i_start = 1'b0;
            end
            repeat (3) @(negedge clk);
        end
        check("b_done_c31", 64'(ifb.o_done), 64'd1);
        check("b_dw", 64'(ifb.o_dw), 64'(dwx));
        ifb.i_start = 1'b1;
        @(negedge clk);
        ifb.i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("b_no_restart", 64'(ifb.o_busy), 64'd0);
        check("b_wcnt", 64'(wcnt_b), 64'd6);
        check("b_dcnt", 64'(dcnt_b), 64'd1);
        check("b_q_empty", 64'(qb.size()), 64'd0);

        // Reset during WR of element 2
        for (int e = 0; e < 3; e++) qb.push_back('{a: 12'(e), d: m_w(dwx, wv, 32'h00800000)});
        pulse_start(1);
        repeat (14) @(negedge clk);
        check("b_wr_e2", 64'(ifb.o_wr_w), 64'd1);
        check("b_wr_e2_addr", 64'(ifb.o_wr_addr_w), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("b_rst_wr", 64'(ifb.o_wr_w), 64'd0);
        check("b_rst_busy", 64'(ifb.o_busy), 64'd0);
        check("b_rst_addr_d", 64'(ifb.o_rd_addr_d), 64'd0);
        check("b_rst_addr_x", 64'(ifb.o_rd_addr_x), 64'd0);
        check("b_rst_addr_w", 64'(ifb.o_rd_addr_w), 64'd0);
        check("b_rst_q", 64'(qb.size()), 64'd0);

        // Fresh run after reset: first element must be computed from scratch
        d = 32'h01000000; x = 32'h01000000; wv = 32'h03000000;
        ifb.i_dgate = d; ifb.i_x = x; ifb.i_w = wv;
        dwx = m_dw(d, x, 2);
        qb.push_back('{a: 12'd0, d: m_w(dwx, wv, 32'h00800000)});
        n = wcnt_b;
        pulse_start(1);
        for (int c = 0; c < 20 && wcnt_b == n; c++) @(negedge clk);
        check("b_fresh_wr", 64'(wcnt_b - n), 64'd1);
        check("b_fresh_dw", 64'(ifb.o_dw), 64'(dwx));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("b_fresh_q", 64'(qb.size()), 64'd0);

        // Saturation, positive then mirrored
        ifc.i_dgate = 32'hFF000000; ifc.i_x = 32'h7F000000; ifc.i_w = 32'h7FFFFFF0;
        qc.push_back('{a: 12'd0, d: 32'h7FFFFFFF});
        pulse_start(2);
        wait_done(2, n);
        check("c_dw_neg", 64'(ifc.o_dw), 64'(m_dw(32'hFF000000, 32'h7F000000, 2)));
        ifc.i_dgate = 32'h01000000; ifc.i_x = 32'h7F000000; ifc.i_w = 32'h80000010;
        qc.push_back('{a: 12'd0, d: 32'h80000000});
        pulse_start(2);
        wait_done(2, n);
        check("c_dw_pos", 64'(ifc.o_dw), 64'(m_dw(32'h01000000, 32'h7F000000, 2)));
        repeat (2) @(negedge clk);
        check("c_wcnt", 64'(wcnt_c), 64'd2);
        check("a_q_empty", 64'(qa.size()), 64'd0);
        check("c_q_empty", 64'(qc.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
